// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC measurement sequencer.
// FSM encoding, readout byte indices and width helpers.
package tdc_pkg;

  localparam int COUNT_W_DEF = 32;
  localparam int SUM_XW      = 4;
  localparam int SUM_W_DEF   = COUNT_W_DEF + SUM_XW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_STOP  = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] RD_MIN0 = 4'd0;
  localparam logic [3:0] RD_MIN1 = 4'd1;
  localparam logic [3:0] RD_MIN2 = 4'd2;
  localparam logic [3:0] RD_MIN3 = 4'd3;
  localparam logic [3:0] RD_MAX0 = 4'd4;
  localparam logic [3:0] RD_MAX1 = 4'd5;
  localparam logic [3:0] RD_MAX2 = 4'd6;
  localparam logic [3:0] RD_MAX3 = 4'd7;
  localparam logic [3:0] RD_SUM0 = 4'd8;
  localparam logic [3:0] RD_SUM1 = 4'd9;
  localparam logic [3:0] RD_SUM2 = 4'd10;
  localparam logic [3:0] RD_SUM3 = 4'd11;
  localparam logic [3:0] RD_SUM4 = 4'd12;
  localparam logic [3:0] RD_STAT = 4'd13;

endpackage

// File: rtl/tdc_stats_acc.sv
// Min/max/sum/saturation accumulator for TDC samples.
// Exposes next-state values so results can be latched on the last update.
module tdc_stats_acc
  import tdc_pkg::*;
#(
  parameter int                 COUNT_W   = COUNT_W_DEF,
  parameter logic [COUNT_W-1:0] SAT_LIMIT = '1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_init,
  input  logic                      i_upd,
  input  logic [COUNT_W-1:0]        i_sample,
  output logic [COUNT_W-1:0]        o_nxt_min,
  output logic [COUNT_W-1:0]        o_nxt_max,
  output logic [COUNT_W+SUM_XW-1:0] o_nxt_sum,
  output logic                      o_nxt_sat
);

  localparam int SUM_W = COUNT_W + SUM_XW;

  logic [COUNT_W-1:0] r_min;
  logic [COUNT_W-1:0] r_max;
  logic [SUM_W-1:0]   r_sum;
  logic               r_sat;
  logic               w_clamp;
  logic [COUNT_W-1:0] w_s;

  assign w_clamp = (i_sample >= SAT_LIMIT);
  assign w_s     = w_clamp ? SAT_LIMIT : i_sample;

  // Next accumulator values: init seeds, update folds in a clamped sample
  always_comb begin
    o_nxt_min = r_min;
    o_nxt_max = r_max;
    o_nxt_sum = r_sum;
    o_nxt_sat = r_sat;
    if (i_init) begin
      o_nxt_min = '1;
      o_nxt_max = '0;
      o_nxt_sum = '0;
      o_nxt_sat = 1'b0;
    end else if (i_upd) begin
      if (w_s < r_min) o_nxt_min = w_s;
      if (w_s > r_max) o_nxt_max = w_s;
      o_nxt_sum = r_sum + SUM_W'(w_s);
      o_nxt_sat = r_sat | w_clamp;
    end
  end

  // Accumulator state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_min <= '0;
      r_max <= '0;
      r_sum <= '0;
      r_sat <= 1'b0;
    end else begin
      r_min <= o_nxt_min;
      r_max <= o_nxt_max;
      r_sum <= o_nxt_sum;
      r_sat <= o_nxt_sat;
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the ring-oscillator TDC.
// Runs N clear/start/stop/capture cycles and reports min/max/sum.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int                 COUNT_W   = COUNT_W_DEF,
  parameter int                 SETTLE    = 2,
  parameter logic [COUNT_W-1:0] SAT_LIMIT = '1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_go,
  input  logic [7:0]                i_cfg_delay,
  input  logic [3:0]                i_cfg_samples,
  input  logic [COUNT_W-1:0]        i_tdc_count,
  output logic                      o_tdc_clear,
  output logic                      o_tdc_start,
  output logic                      o_tdc_stop,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [COUNT_W-1:0]        o_res_min,
  output logic [COUNT_W-1:0]        o_res_max,
  output logic [COUNT_W+SUM_XW-1:0] o_res_sum,
  output logic                      o_sat,
  input  logic [3:0]                i_rd_sel,
  output logic [7:0]                o_rd_byte
);

  localparam int         SUM_W     = COUNT_W + SUM_XW;
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  state_t             r_state;
  logic [7:0]         r_delay;
  logic [7:0]         r_cnt;
  logic [3:0]         r_nsamp;
  logic [3:0]         r_idx;
  logic               r_clear;
  logic               r_start;
  logic               r_stop;
  logic               r_busy;
  logic               r_done;
  logic [COUNT_W-1:0] r_res_min;
  logic [COUNT_W-1:0] r_res_max;
  logic [SUM_W-1:0]   r_res_sum;
  logic               r_res_sat;

  logic               w_init;
  logic               w_upd;
  logic               w_last;
  logic [COUNT_W-1:0] w_nxt_min;
  logic [COUNT_W-1:0] w_nxt_max;
  logic [SUM_W-1:0]   w_nxt_sum;
  logic               w_nxt_sat;
  logic [31:0]        w_min32;
  logic [31:0]        w_max32;
  logic [39:0]        w_sum40;
  logic [7:0]         w_rd;

  assign w_init = (r_state == S_IDLE) && i_go;
  assign w_upd  = (r_state == S_CAPT);
  assign w_last = (r_idx == r_nsamp - 4'd1);

  tdc_stats_acc #(
    .COUNT_W   (COUNT_W),
    .SAT_LIMIT (SAT_LIMIT)
  ) u_acc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_init    (w_init),
    .i_upd     (w_upd),
    .i_sample  (i_tdc_count),
    .o_nxt_min (w_nxt_min),
    .o_nxt_max (w_nxt_max),
    .o_nxt_sum (w_nxt_sum),
    .o_nxt_sat (w_nxt_sat)
  );

  // Sequencer FSM with registered TDC controls and results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_delay   <= '0;
      r_cnt     <= '0;
      r_nsamp   <= '0;
      r_idx     <= '0;
      r_clear   <= 1'b0;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_res_min <= '0;
      r_res_max <= '0;
      r_res_sum <= '0;
      r_res_sat <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_delay <= i_cfg_delay;
            r_nsamp <= i_cfg_samples;
            r_idx   <= '0;
            r_clear <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_clear <= 1'b0;
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == r_delay) begin
            r_start <= 1'b0;
            r_stop  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_STOP: begin
          if (r_cnt == SETTLE_M1) begin
            r_state <= S_CAPT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_CAPT: begin
          r_stop <= 1'b0;
          if (w_last) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_res_min <= w_nxt_min;
            r_res_max <= w_nxt_max;
            r_res_sum <= w_nxt_sum;
            r_res_sat <= w_nxt_sat;
            r_state   <= S_DONE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_clear <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_min32 = 32'(r_res_min);
  assign w_max32 = 32'(r_res_max);
  assign w_sum40 = 40'(r_res_sum);

  // Byte-wide readout mux for the 8-bit output pins
  always_comb begin
    w_rd = 8'h00;
    case (i_rd_sel)
      RD_MIN0: w_rd = w_min32[7:0];
      RD_MIN1: w_rd = w_min32[15:8];
      RD_MIN2: w_rd = w_min32[23:16];
      RD_MIN3: w_rd = w_min32[31:24];
      RD_MAX0: w_rd = w_max32[7:0];
      RD_MAX1: w_rd = w_max32[15:8];
      RD_MAX2: w_rd = w_max32[23:16];
      RD_MAX3: w_rd = w_max32[31:24];
      RD_SUM0: w_rd = w_sum40[7:0];
      RD_SUM1: w_rd = w_sum40[15:8];
      RD_SUM2: w_rd = w_sum40[23:16];
      RD_SUM3: w_rd = w_sum40[31:24];
      RD_SUM4: w_rd = w_sum40[39:32];
      RD_STAT: w_rd = {r_res_sat, r_busy, 2'b00, r_idx};
      default: w_rd = 8'h00;
    endcase
  end

  assign o_tdc_clear = r_clear;
  assign o_tdc_start = r_start;
  assign o_tdc_stop  = r_stop;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_res_min   = r_res_min;
  assign o_res_max   = r_res_max;
  assign o_res_sum   = r_res_sum;
  assign o_sat       = r_res_sat;
  assign o_rd_byte   = w_rd;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for the TDC measurement sequencer.
// Two instances: default saturation limit and a limit of 1000.
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [7:0]  cfg_delay;
  logic [3:0]  cfg_samples;
  logic [31:0] tdc_count;
  logic [3:0]  rd_sel;

  logic        tdc_clear, tdc_start, tdc_stop, busy, done, sat;
  logic [31:0] res_min, res_max;
  logic [35:0] res_sum;
  logic [7:0]  rd_byte;

  logic        tdc_clear2, tdc_start2, tdc_stop2, busy2, done2, sat2;
  logic [31:0] res_min2, res_max2;
  logic [35:0] res_sum2;
  logic [7:0]  rd_byte2;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] smp [16];

  always #5 clk = ~clk;

  tdc_meas_ctrl u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_go          (go),
    .i_cfg_delay   (cfg_delay),
    .i_cfg_samples (cfg_samples),
    .i_tdc_count   (tdc_count),
    .o_tdc_clear   (tdc_clear),
    .o_tdc_start   (tdc_start),
    .o_tdc_stop    (tdc_stop),
    .o_busy        (busy),
    .o_done        (done),
    .o_res_min     (res_min),
    .o_res_max     (res_max),
    .o_res_sum     (res_sum),
    .o_sat         (sat),
    .i_rd_sel      (rd_sel),
    .o_rd_byte     (rd_byte)
  );

  tdc_meas_ctrl #(
    .SAT_LIMIT (32'd1000)
  ) u_dut_lim (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_go          (go),
    .i_cfg_delay   (cfg_delay),
    .i_cfg_samples (cfg_samples),
    .i_tdc_count   (tdc_count),
    .o_tdc_clear   (tdc_clear2),
    .o_tdc_start   (tdc_start2),
    .o_tdc_stop    (tdc_stop2),
    .o_busy        (busy2),
    .o_done        (done2),
    .o_res_min     (res_min2),
    .o_res_max     (res_max2),
    .o_res_sum     (res_sum2),
    .o_sat         (sat2),
    .i_rd_sel      (rd_sel),
    .o_rd_byte     (rd_byte2)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [3:0] sel,
                          input logic [7:0] exp);
    rd_sel = sel;
    #1;
    check(tag, rd_byte, exp);
  endtask

  // Pulse go, then step cycles 1..exp_cyc+3 feeding smp[(c-1)/per]
  task automatic run(input string nm, input int per, input int exp_cyc,
                     input bit trace, input bit midgo);
    int dcnt;
    int dcyc;
    int si;
    dcnt = 0;
    dcyc = -1;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    for (int c = 1; c <= exp_cyc + 3; c++) begin
      si = (c - 1) / per;
      if (si > 15) si = 15;
      tdc_count = smp[si];
      if (midgo && c == 3) begin
        go = 1'b1;
        cfg_delay = 8'd200;
        cfg_samples = 4'd9;
      end
      if (midgo && c == 4) go = 1'b0;
      @(negedge clk);
      if (trace)
        check($sformatf("%s ctl c%0d", nm, c),
              {tdc_clear, tdc_start, tdc_stop, busy, done},
              {c == 1, c >= 2 && c <= 6, c >= 7 && c <= 9,
               c >= 1 && c <= 9, c == 10});
      if (done) begin
        dcnt++;
        dcyc = c;
      end
      @(posedge clk); #1;
    end
    check($sformatf("%s done_cnt", nm), dcnt, 1);
    check($sformatf("%s done_cyc", nm), dcyc, exp_cyc);
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    cfg_delay = 8'd0;
    cfg_samples = 4'd1;
    tdc_count = '0;
    rd_sel = 4'd0;
    for (int i = 0; i < 16; i++) smp[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst ctl", {tdc_clear, tdc_start, tdc_stop, busy, done}, 0);
    check("rst min", res_min, 0);
    check("rst sum", res_sum, 0);
    check("rst sat", sat, 0);
    rd_check("rst rd13", 4'd13, 8'h00);

    // D=4, N=1, sample 100
    cfg_delay = 8'd4;
    cfg_samples = 4'd1;
    smp[0] = 32'd100;
    run("t1", 9, 10, 1'b1, 1'b0);
    check("t1 min", res_min, 100);
    check("t1 max", res_max, 100);
    check("t1 sum", res_sum, 100);
    rd_check("t1 rd0", 4'd0, 8'h64);

    // D=0, N=4, samples 7 3 9 5
    cfg_delay = 8'd0;
    cfg_samples = 4'd4;
    smp[0] = 32'd7; smp[1] = 32'd3; smp[2] = 32'd9; smp[3] = 32'd5;
    run("t2", 5, 21, 1'b0, 1'b0);
    check("t2 min", res_min, 3);
    check("t2 max", res_max, 9);
    check("t2 sum", res_sum, 24);
    check("t2 sat", sat, 0);
    rd_check("t2 rd8", 4'd8, 8'h18);
    rd_check("t2 rd4", 4'd4, 8'h09);
    rd_check("t2 rd13", 4'd13, 8'h03);

    // N=16 at all-ones
    cfg_samples = 4'd0;
    for (int i = 0; i < 16; i++) smp[i] = 32'hFFFF_FFFF;
    run("t3", 5, 81, 1'b0, 1'b0);
    check("t3 min", res_min, 32'hFFFF_FFFF);
    check("t3 max", res_max, 32'hFFFF_FFFF);
    check("t3 sum", res_sum, 36'hF_FFFF_FFF0);
    check("t3 sat", sat, 1);
    rd_check("t3 rd12", 4'd12, 8'h0F);
    rd_check("t3 rd14", 4'd14, 8'h00);

    // Mid-run go and config changes are ignored
    cfg_delay = 8'd4;
    cfg_samples = 4'd2;
    smp[0] = 32'd10; smp[1] = 32'd20;
    run("t4", 9, 19, 1'b0, 1'b1);
    check("t4 min", res_min, 10);
    check("t4 max", res_max, 20);
    check("t4 sum", res_sum, 30);
    check("t4 sat", sat, 0);

    // Reset during START
    cfg_delay = 8'd4;
    cfg_samples = 4'd1;
    for (int i = 0; i < 16; i++) smp[i] = 32'd100;
    tdc_count = 32'd100;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5 pre start", tdc_start, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t5 rst ctl", {tdc_clear, tdc_start, tdc_stop, busy, done}, 0);
    check("t5 rst min", res_min, 0);
    check("t5 rst sum", res_sum, 0);
    rd_check("t5 rd13", 4'd13, 8'h00);
    run("t5", 9, 10, 1'b0, 1'b0);
    check("t5 min", res_min, 100);
    check("t5 sum", res_sum, 100);

    // Clamp at 1000 on the limited instance
    cfg_delay = 8'd0;
    cfg_samples = 4'd1;
    smp[0] = 32'd5000;
    run("t6", 5, 6, 1'b0, 1'b0);
    check("t6 lim min", res_min2, 1000);
    check("t6 lim max", res_max2, 1000);
    check("t6 lim sum", res_sum2, 1000);
    check("t6 lim sat", sat2, 1);
    rd_sel = 4'd13;
    #1;
    check("t6 lim rd13", rd_byte2, 8'h80);
    check("t6 def min", res_min, 5000);
    check("t6 def sat", sat, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the ring-oscillator TDC (`tdc_delay`).
- On a `go` pulse it runs N back-to-back measurements. Each one clears the TDC, raises start, waits a programmable delay, raises stop and lets the count settle.
- It then captures the TDC count and keeps min/max/sum statistics.
- It sits between the top-level pin wrapper and the TDC, and exposes the results through a byte-wide readout mux that fits the 8-bit output pins.

Parameters:
- COUNT_W, 32, width of the TDC count input.
- SETTLE, 2, cycles stop is held before capture (range 1..15).
- SAT_LIMIT, 32'hFFFF_FFFF, a sample >= this value is clamped to it and sets the sticky sat flag.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- go  in  1  one-cycle request to start a run; ignored unless the FSM is in IDLE
- cfg_delay  in  8  start-to-stop delay D in cycles; start is high for D+1 cycles
- cfg_samples  in  4  number of samples N; 0 encodes 16
- tdc_count  in  COUNT_W  TDC transition count
- tdc_clear  out  1  clears the TDC counter
- tdc_start  out  1  TDC start
- tdc_stop  out  1  TDC stop
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, results valid
- res_min  out  COUNT_W  minimum sample
- res_max  out  COUNT_W  maximum sample
- res_sum  out  COUNT_W+4  sum of samples
- sat  out  1  at least one sample was clamped in the last run
- rd_sel  in  4  readout byte select
- rd_byte  out  8  selected byte, combinational from registers

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, sample index 0.
- Reset mid-run: abort immediately. No done pulse. Results are cleared to 0.
- FSM states: IDLE, CLEAR, START, STOP, CAPTURE, DONE.
- IDLE:
  - go=1 latches cfg_delay and cfg_samples. Later changes to these inputs have no effect on the run.
  - Accumulators initialise to min=all-ones, max=0, sum=0, sat=0.
  - Next state: CLEAR.
- CLEAR (1 cycle): tdc_clear=1. Next state: START.
- START (D+1 cycles): tdc_start=1, counted by a delay counter. Next state: STOP.
- STOP (SETTLE cycles): tdc_start=0, tdc_stop=1. Next state: CAPTURE.
- CAPTURE (1 cycle):
  - tdc_stop remains 1.
  - Sample s = min(tdc_count, SAT_LIMIT); the internal sat flag is set if clamped.
  - Update min, max and sum (zero-extended add).
  - If index == N-1, go to DONE; otherwise index++ and go to CLEAR.
- DONE (1 cycle):
  - done=1, busy=0.
  - Registered outputs res_min, res_max, res_sum and sat update from the accumulators; they hold until the next DONE or rst.
  - Next state: IDLE.
- busy=1 in CLEAR, START, STOP and CAPTURE.
- At most one of tdc_clear, tdc_start, tdc_stop is high in any cycle.
- Latency: go sampled at edge k gives done high in cycle k + N*(D+SETTLE+3) + 1.
- Width rules:
  - sum is COUNT_W+4 bits, so 16 samples at max value cannot overflow.
  - The min comparison is unsigned.
  - With N=1: min = max = sum.
- go asserted while busy or in DONE is dropped, not queued.
- rd_sel map:
  - 0-3: res_min bytes, LSB first.
  - 4-7: res_max bytes.
  - 8-12: res_sum bytes; the upper 4 bits of byte 12 are 0.
  - 13: {sat, busy, 2'b0, sample index[3:0]}.
  - 14-15: 8'h00.

Decomposition:
- Package tdc_pkg holds:
  - the state enum (6 states, 3-bit encoding);
  - the rd_sel index constants;
  - the default COUNT_W;
  - the localparam for the sum width.
- One natural sub-module, tdc_stats_acc: the min/max/sum/saturation accumulator with init and update strobes.
- The readout mux stays inline.

Test Plan:
- D=4, SETTLE=2, N=1, tdc_count=100.
  - Expect tdc_clear in cycle 1, tdc_start in cycles 2-6, tdc_stop in cycles 7-9, done in cycle 10.
  - Expect res_min = res_max = 100, res_sum = 100.
- D=0, N=4, samples 7, 3, 9, 5.
  - Expect min=3, max=9, sum=24.
  - Expect done at cycle 4*5+1 = 21.
  - rd_sel=8 gives 8'h18.
- cfg_samples=0, every sample 32'hFFFF_FFFF, SAT_LIMIT default.
  - Expect 16 samples, res_sum = 36'hF_FFFF_FFF0, sat=1.
  - rd_sel=12 gives 8'h0F.
- go pulsed again mid-run, and cfg_delay changed mid-run.
  - The run completes unchanged, with exactly one done pulse.
- rst asserted during START.
  - Next cycle: all TDC controls, busy and results are 0, and the FSM is in IDLE.
  - A new go then runs normally.
- SAT_LIMIT=1000, sample 5000.
  - Sample clamped to 1000, sat=1.
  - rd_sel=13 shows bit7=1.
